vmem_uart_dump: RTL and testbench
=================================

Name: vmem_uart_dump

Overview:
- Streams a window of data memory out over a UART TX line, for debug and inspection.
- Sits downstream of the data memory's read-only video port: it drives vaddr and consumes vdata, without disturbing the CPU's addr/read_data/write path.
- On a start pulse it walks WORDS consecutive words and sends each word's 4 bytes LSB-first, 8N1 framing.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535.
- WORDS, 32, number of words dumped per start; legal range 1..128.
- BASE_ADDR, 9'h000, byte address of the first word; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; ignored while busy=1.
- vaddr  output  9  byte address presented to the memory video port; always word aligned.
- vdata  input  32  combinational read data for vaddr, valid in the same cycle.
- tx  output  1  UART serial out; idle high.
- busy  output  1  high from the cycle after start is accepted until the cycle done pulses.
- done  output  1  one-cycle pulse after the last stop bit of the last byte.

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: tx=1, busy=0, done=0, vaddr=BASE_ADDR. Internal state goes to IDLE, and all bit, byte and word counters clear.
- All outputs are registered.
- FSM states: IDLE, LOAD, START, DATA, STOP, FIN.
- IDLE:
  - tx=1, vaddr=BASE_ADDR.
  - start=1 moves to LOAD next edge, with busy=1 and word counter=0.
- LOAD (exactly 1 cycle per word):
  - vaddr is stable for the whole cycle.
  - vdata is captured into a 32-bit shift register at the end of the cycle; byte counter=0.
  - Next state is START.
  - Memory writes after the capture edge do not affect the word in flight.
- START: tx=0 for exactly CLKS_PER_BIT cycles.
- DATA:
  - 8 bits, each held exactly CLKS_PER_BIT cycles.
  - Bit order is bit0 first of the current byte; the current byte is shift[7:0].
- STOP:
  - tx=1 for exactly CLKS_PER_BIT cycles.
  - Then the shift register shifts right by 8 and the byte counter increments.
  - If byte counter < 3, go to START.
  - Else, if word counter < WORDS-1: vaddr += 4, word counter increments, go to LOAD.
  - Else go to FIN.
- FIN (1 cycle):
  - done=1 and busy drops to 0 in the same cycle; vaddr returns to BASE_ADDR.
  - Next state is IDLE.
- Timing:
  - Byte frame = 10*CLKS_PER_BIT cycles, with no idle gap between bytes of a word.
  - Gap between words is the single LOAD cycle, with tx=1.
  - Total busy cycles = WORDS*(1+40*CLKS_PER_BIT)+1 (defaults: 20513).
- Bit-period counter:
  - 16 bits, counts 0..CLKS_PER_BIT-1.
  - Reloads on every state or bit change; no drift across bytes.
- vaddr:
  - Increments by 4 modulo 512.
  - BASE_ADDR+4*WORDS exceeding 511 wraps to 0; the dump continues and this is not an error.
- start handling:
  - start while busy=1 is dropped, not queued.
  - start asserted in the FIN cycle is ignored.
  - start in IDLE on the cycle after FIN is accepted.
- Reset mid-operation takes priority over everything:
  - tx=1 on the next edge, with no stop bit completion.
  - No done pulse is generated.

Test Plan:
- Reset: hold reset 3 cycles mid-stream -> tx=1, busy=0, done=0, vaddr=0x000 after the first edge; no done pulse afterwards.
- Single word, WORDS=1, CLKS_PER_BIT=16, memory word0=0x12345678 -> bytes 0x78,0x56,0x34,0x12 decoded in order. Each start bit is low exactly 16 cycles. done pulses at cycle 642 after start, then busy=0.
- Full dump, defaults, words i=0..31 with value 0xA5000000|i -> vaddr steps 0x000,0x004,...,0x07C. 128 bytes received matching. busy high for 20513 cycles. Single done pulse.
- start re-asserted at cycles 5, 300 and in the FIN cycle -> exactly one dump transmitted; a start one cycle after FIN starts a second dump.
- Snapshot: write 0xDEADBEEF to word 0 two cycles after its LOAD -> first word still sends the pre-write value; a second dump sends 0xEF,0xBE,0xAD,0xDE.
- Wrap: BASE_ADDR=0x1F8, WORDS=4 -> vaddr sequence 0x1F8,0x1FC,0x000,0x004; done pulses normally.

Source files
------------

// File: rtl/vmem_uart_dump.sv
// Debug dumper: walks a window of data memory through the read-only video port
// and streams each word LSB-byte-first over an 8N1 UART transmit line.
module vmem_uart_dump #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned WORDS        = 32,
  parameter logic [8:0]  BASE_ADDR    = 9'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [8:0]  vaddr,
  input  logic [31:0] vdata,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, FIN} state_t;

  localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);
  localparam logic [6:0]  LAST_WORD = 7'(WORDS - 1);

  state_t      state;
  logic [15:0] tick;
  logic [2:0]  bit_idx;
  logic [1:0]  byte_cnt;
  logic [6:0]  word_cnt;
  logic [31:0] shreg;

  logic       bit_end;
  logic [2:0] next_bit_idx;

  assign bit_end      = (tick == LAST_TICK);
  assign next_bit_idx = bit_idx + 3'd1;

  // NOTE: every register in this block is assigned with <= so all updates land
  // together at the edge; a blocking = here would let later statements see
  // half-updated state and break the bit timing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tick     <= '0;
      bit_idx  <= '0;
      byte_cnt <= '0;
      word_cnt <= '0;
      shreg    <= '0;
      vaddr    <= BASE_ADDR;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx    <= 1'b1;
          vaddr <= BASE_ADDR;
          tick  <= '0;
          if (start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            word_cnt <= '0;
          end
        end

        // The word is snapshotted here, so later memory writes cannot corrupt
        // the bytes still being shifted out.
        LOAD: begin
          shreg    <= vdata;
          byte_cnt <= '0;
          tick     <= '0;
          tx       <= 1'b0;
          state    <= START;
        end

        START: begin
          if (bit_end) begin
            tick    <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            tick <= tick + 16'd1;
          end
        end

        DATA: begin
          if (bit_end) begin
            tick <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= next_bit_idx;
              tx      <= shreg[next_bit_idx];
            end
          end else begin
            tick <= tick + 16'd1;
          end
        end

        STOP: begin
          if (bit_end) begin
            tick     <= '0;
            shreg    <= shreg >> 8;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt != 2'd3) begin
              tx    <= 1'b0;
              state <= START;
            end else if (word_cnt < LAST_WORD) begin
              // 9-bit add wraps past 511 back to 0 by design.
              vaddr    <= vaddr + 9'd4;
              word_cnt <= word_cnt + 7'd1;
              state    <= LOAD;
            end else begin
              state <= FIN;
            end
          end else begin
            tick <= tick + 16'd1;
          end
        end

        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          vaddr <= BASE_ADDR;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vmem_uart_dump.sv
// Directed bench for vmem_uart_dump: three instances (defaults, single word,
// wrapping window) checked cycle by cycle against a timing model of the frame.
module tb_vmem_uart_dump;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic tx_a, tx_b, tx_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [8:0]  vaddr_a, vaddr_b, vaddr_c;
  logic [31:0] vdata_a, vdata_b, vdata_c;
  logic [31:0] mem_a [128];
  logic [31:0] mem_b [128];
  logic [31:0] mem_c [128];
  logic [31:0] exp_w [128];

  assign vdata_a = mem_a[vaddr_a[8:2]];
  assign vdata_b = mem_b[vaddr_b[8:2]];
  assign vdata_c = mem_c[vaddr_c[8:2]];

  vmem_uart_dump u_a (
    .clk(clk), .reset(reset), .start(start_a), .vaddr(vaddr_a),
    .vdata(vdata_a), .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  vmem_uart_dump #(.CLKS_PER_BIT(16), .WORDS(1), .BASE_ADDR(9'h000)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .vaddr(vaddr_b),
    .vdata(vdata_b), .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  vmem_uart_dump #(.CLKS_PER_BIT(2), .WORDS(4), .BASE_ADDR(9'h1F8)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .vaddr(vaddr_c),
    .vdata(vdata_c), .tx(tx_c), .busy(busy_c), .done(done_c)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic get_tx(input int id);
    case (id)
      0: return tx_a;
      1: return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic get_busy(input int id);
    case (id)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic get_done(input int id);
    case (id)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic [8:0] get_vaddr(input int id);
    case (id)
      0: return vaddr_a;
      1: return vaddr_b;
      default: return vaddr_c;
    endcase
  endfunction

  task automatic set_start(input int id, input logic v);
    case (id)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  // One dump, sampled #1 after every edge. k counts edges after the accepting
  // edge: k=0 is the first LOAD cycle, k=t is the done cycle.
  task automatic dump(input int id, input int words, input int cpb, input logic [8:0] base,
                      input string tag, input bit pre, input bit restart_en,
                      input bit chain_en, input bit poke_en);
    int len, t, last_k, w, p, b, s, ww;
    int tx_err, busy_err, vaddr_err, byte_err, busy_cnt, done_cnt, done_k;
    logic exp_tx, exp_busy;
    logic [8:0] exp_va;
    logic [7:0] rx;
    len = 1 + 40 * cpb;
    t = words * len + 1;
    last_k = chain_en ? t : t + 3;
    tx_err = 0; busy_err = 0; vaddr_err = 0; byte_err = 0;
    busy_cnt = 0; done_cnt = 0; done_k = -1; rx = '0;
    if (!pre) begin
      @(negedge clk);
      set_start(id, 1'b1);
    end
    @(posedge clk);
    #1;
    set_start(id, 1'b0);
    for (int k = 0; k <= last_k; k++) begin
      exp_tx = 1'b1;
      if (k < t - 1) begin
        w = k / len;
        p = k % len - 1;
        if (p >= 0) begin
          b = p / (10 * cpb);
          s = (p % (10 * cpb)) / cpb;
          if (s == 0) exp_tx = 1'b0;
          else if (s == 9) exp_tx = 1'b1;
          else exp_tx = exp_w[w][8 * b + s - 1];
          if (s >= 1 && s <= 8 && (p % cpb) == cpb / 2) begin
            rx = {get_tx(id), rx[7:1]};
            if (s == 8 && rx !== exp_w[w][8 * b +: 8]) byte_err++;
          end
        end
      end
      exp_busy = (k < t);
      ww = (k / len < words) ? k / len : words - 1;
      exp_va = (k >= t) ? base : base + 9'(4 * ww);
      if (get_tx(id) !== exp_tx) tx_err++;
      if (get_busy(id) !== exp_busy) busy_err++;
      if (get_busy(id) === 1'b1) busy_cnt++;
      if (get_vaddr(id) !== exp_va) vaddr_err++;
      if (get_done(id) === 1'b1) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (k % len == 0 && k < t - 1)
        check($sformatf("%s_load_vaddr_w%0d", tag, k / len), 32'(get_vaddr(id)), 32'(exp_va));
      set_start(id, (restart_en && (k == 5 || k == 300 || k == t - 1)) || (chain_en && k == t));
      if (poke_en && k == 2) mem_b[0] = 32'hDEADBEEF;
      if (k < last_k) begin
        @(posedge clk);
        #1;
      end
    end
    check($sformatf("%s_tx_wave_errs", tag), tx_err, 0);
    check($sformatf("%s_byte_errs", tag), byte_err, 0);
    check($sformatf("%s_busy_errs", tag), busy_err, 0);
    check($sformatf("%s_busy_cycles", tag), busy_cnt, t);
    check($sformatf("%s_vaddr_errs", tag), vaddr_err, 0);
    check($sformatf("%s_done_pulses", tag), done_cnt, 1);
    check($sformatf("%s_done_at", tag), done_k, t);
  endtask

  initial begin
    int lows, busies, dones;
    for (int i = 0; i < 128; i++) begin
      mem_a[i] = 32'hA5000000 | 32'(i);
      mem_b[i] = 32'h0;
      mem_c[i] = 32'h0;
      exp_w[i] = 32'h0;
    end
    mem_b[0]   = 32'h12345678;
    mem_c[126] = 32'h11223344;
    mem_c[127] = 32'h55667788;
    mem_c[0]   = 32'h99AABBCC;
    mem_c[1]   = 32'hDDEEFF00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_a", 32'(tx_a), 1);
    check("rst_busy_a", 32'(busy_a), 0);
    check("rst_done_a", 32'(done_a), 0);
    check("rst_vaddr_a", 32'(vaddr_a), 32'h000);
    check("rst_vaddr_c", 32'(vaddr_c), 32'h1F8);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Single word: bytes 0x78,0x56,0x34,0x12, done at edge 642.
    exp_w[0] = 32'h12345678;
    dump(1, 1, 16, 9'h000, "single", 1'b0, 1'b0, 1'b0, 1'b0);
    // Restarts at k=5, 300 and in the FIN cycle must all be dropped.
    dump(1, 1, 16, 9'h000, "restart", 1'b0, 1'b1, 1'b0, 1'b0);
    // A start in the done cycle (IDLE right after FIN) launches another dump.
    dump(1, 1, 16, 9'h000, "chain1", 1'b0, 1'b1, 1'b1, 1'b0);
    dump(1, 1, 16, 9'h000, "chain2", 1'b1, 1'b0, 1'b0, 1'b0);
    // Snapshot: write after the capture edge does not touch the word in flight.
    dump(1, 1, 16, 9'h000, "snap1", 1'b0, 1'b0, 1'b0, 1'b1);
    exp_w[0] = 32'hDEADBEEF;
    dump(1, 1, 16, 9'h000, "snap2", 1'b0, 1'b0, 1'b0, 1'b0);

    // Wrap: 0x1F8, 0x1FC, 0x000, 0x004.
    exp_w[0] = 32'h11223344;
    exp_w[1] = 32'h55667788;
    exp_w[2] = 32'h99AABBCC;
    exp_w[3] = 32'hDDEEFF00;
    dump(2, 4, 2, 9'h1F8, "wrap", 1'b0, 1'b0, 1'b0, 1'b0);

    // Full default dump: 32 words, 20513 busy cycles.
    for (int i = 0; i < 32; i++) exp_w[i] = 32'hA5000000 | 32'(i);
    dump(0, 32, 16, 9'h000, "full", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid start bit of byte 1 (k=166): tx must return high at once.
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (166) @(posedge clk);
    #1;
    check("midrst_pre_tx", 32'(tx_a), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tx", 32'(tx_a), 1);
    check("midrst_busy", 32'(busy_a), 0);
    check("midrst_done", 32'(done_a), 0);
    check("midrst_vaddr", 32'(vaddr_a), 32'h000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    lows = 0; busies = 0; dones = 0;
    for (int k = 0; k < 700; k++) begin
      @(posedge clk);
      #1;
      if (tx_a !== 1'b1) lows++;
      if (busy_a !== 1'b0) busies++;
      if (done_a !== 1'b0) dones++;
    end
    check("post_rst_tx_low", lows, 0);
    check("post_rst_busy", busies, 0);
    check("post_rst_done", dones, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
